// File: rtl/calc_vector_driver.sv
// Self-test initiator for the calculator's go/done interface.
// Sweeps all 256 {in1, in2, op} vectors and checks each result against a golden model.
module calc_vector_driver #(
    parameter int TIMEOUT      = 32,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       go,
    output logic [1:0] op,
    output logic [2:0] in1,
    output logic [2:0] in2,
    input  logic       done,
    input  logic [2:0] out,
    output logic       busy,
    output logic       test_done,
    output logic       pass,
    output logic       timeout,
    output logic [8:0] err_count,
    output logic [7:0] fail_idx,
    output logic [2:0] fail_got
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             go_q, go_d;
    logic             busy_q, busy_d;
    logic             test_done_q, test_done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [8:0]       err_count_q, err_count_d;
    logic [7:0]       fail_idx_q, fail_idx_d;
    logic [2:0]       fail_got_q, fail_got_d;

    // Expected result for a vector index, all in 3-bit modular arithmetic.
    function automatic logic [2:0] golden(input logic [7:0] i);
        logic [2:0] a;
        logic [2:0] b;
        a = i[7:5];
        b = i[4:2];
        unique case (i[1:0])
            2'd3:    golden = a + b;
            2'd2:    golden = a - b;
            2'd1:    golden = a & b;
            default: golden = a ^ b;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        timeout_d   = timeout_q;
        err_count_d = err_count_q;
        fail_idx_d  = fail_idx_q;
        fail_got_d  = fail_got_q;

        unique case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    err_count_d = '0;
                    timeout_d   = 1'b0;
                    fail_idx_d  = '0;
                    fail_got_d  = '0;
                    idx_d       = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    wcnt_d  = '0;
                    state_d = S_RELEASE;
                    if (out != golden(idx_q)) begin
                        if (err_count_q != 9'd256) err_count_d = err_count_q + 9'd1;
                        if (err_count_q == 9'd0) begin
                            fail_idx_d = idx_q;
                            fail_got_d = out;
                        end
                    end
                end else if (wcnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!done) begin
                    if ((STOP_ON_FAIL && err_count_q != 9'd0) || idx_q == 8'd255) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_ISSUE;
                    end
                end else if (wcnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        go_d        = (state_d == S_ISSUE) || (state_d == S_WAIT);
        busy_d      = go_d || (state_d == S_RELEASE);
        test_done_d = (state_d == S_FINISH);
        pass_d      = (state_d == S_FINISH) && (err_count_d == 9'd0) && !timeout_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wcnt_q      <= '0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            test_done_q <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_count_q <= '0;
            fail_idx_q  <= '0;
            fail_got_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            go_q        <= go_d;
            busy_q      <= busy_d;
            test_done_q <= test_done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_count_q <= err_count_d;
            fail_idx_q  <= fail_idx_d;
            fail_got_q  <= fail_got_d;
        end
    end

    assign go        = go_q;
    assign busy      = busy_q;
    assign test_done = test_done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err_count = err_count_q;
    assign fail_idx  = fail_idx_q;
    assign fail_got  = fail_got_q;
    assign in1       = idx_q[7:5];
    assign in2       = idx_q[4:2];
    assign op        = idx_q[1:0];

endmodule

// File: tb/tb_calc_vector_driver.sv
// Directed bench: two drivers (abort-on-fail and full-sweep) against a behavioural calculator
// that can be made correct, faulty on one sub vector, silent, or stuck at done = 1.
module tb_calc_vector_driver;

    localparam int TIMEOUT = 32;
    localparam int BUDGET  = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_s [2];
    logic       go_s    [2];
    logic [1:0] op_s    [2];
    logic [2:0] in1_s   [2];
    logic [2:0] in2_s   [2];
    logic       done_s  [2];
    logic [2:0] out_s   [2];
    logic       busy_s  [2];
    logic       tdone_s [2];
    logic       pass_s  [2];
    logic       tmo_s   [2];
    logic [8:0] err_s   [2];
    logic [7:0] fidx_s  [2];
    logic [2:0] fgot_s  [2];

    // 0 = correct, 1 = sub wrong at 2-5, 2 = never done, 3 = done stuck high
    int   mode = 0;
    int   tests = 0;
    int   fails = 0;

    logic g1      [2] = '{1'b0, 1'b0};
    logic done_r  [2] = '{1'b0, 1'b0};
    logic go_prev [2] = '{1'b0, 1'b0};
    int   pulses  [2] = '{0, 0};
    int   hicyc   [2] = '{0, 0};

    always #5 clk = ~clk;

    calc_vector_driver #(.TIMEOUT(TIMEOUT), .STOP_ON_FAIL(1'b1)) u_stop (
        .clk(clk), .rst(rst), .start(start_s[0]), .go(go_s[0]), .op(op_s[0]),
        .in1(in1_s[0]), .in2(in2_s[0]), .done(done_s[0]), .out(out_s[0]),
        .busy(busy_s[0]), .test_done(tdone_s[0]), .pass(pass_s[0]), .timeout(tmo_s[0]),
        .err_count(err_s[0]), .fail_idx(fidx_s[0]), .fail_got(fgot_s[0])
    );

    calc_vector_driver #(.TIMEOUT(TIMEOUT), .STOP_ON_FAIL(1'b0)) u_full (
        .clk(clk), .rst(rst), .start(start_s[1]), .go(go_s[1]), .op(op_s[1]),
        .in1(in1_s[1]), .in2(in2_s[1]), .done(done_s[1]), .out(out_s[1]),
        .busy(busy_s[1]), .test_done(tdone_s[1]), .pass(pass_s[1]), .timeout(tmo_s[1]),
        .err_count(err_s[1]), .fail_idx(fidx_s[1]), .fail_got(fgot_s[1])
    );

    function automatic logic [2:0] calc_ref(input logic [2:0] a, input logic [2:0] b,
                                            input logic [1:0] o);
        case (o)
            2'd3:    calc_ref = a + b;
            2'd2:    calc_ref = a - b;
            2'd1:    calc_ref = a & b;
            default: calc_ref = a ^ b;
        endcase
    endfunction

    // Calculator: done two cycles after go rises, drops one cycle after go falls.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            g1[i]      <= go_s[i];
            done_r[i]  <= go_s[i] && g1[i];
            go_prev[i] <= go_s[i];
            if (go_s[i] && !go_prev[i]) pulses[i] <= pulses[i] + 1;
            if (go_s[i]) hicyc[i] <= hicyc[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            done_s[i] = (mode == 3) ? 1'b1 : (mode == 2) ? 1'b0 : done_r[i];
            out_s[i]  = 3'd0;
            if (done_s[i]) begin
                out_s[i] = calc_ref(in1_s[i], in2_s[i], op_s[i]);
                if (mode == 1 && op_s[i] == 2'd2 && in1_s[i] == 3'd2 && in2_s[i] == 3'd5)
                    out_s[i] = 3'd3;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    task automatic wait_tdone(input int i, input string tag);
        int n;
        n = 0;
        while (!tdone_s[i] && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, tdone_s[i]}, 32'd1);
    endtask

    initial begin
        int p0;
        int h0;
        int n;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_go",    {31'd0, go_s[0]},    32'd0);
        check("rst_busy",  {31'd0, busy_s[0]},  32'd0);
        check("rst_tdone", {31'd0, tdone_s[0]}, 32'd0);
        check("rst_pass",  {31'd0, pass_s[0]},  32'd0);
        check("rst_tmo",   {31'd0, tmo_s[0]},   32'd0);
        check("rst_err",   {23'd0, err_s[0]},   32'd0);
        check("rst_vec",   {24'd0, in1_s[0], in2_s[0], op_s[0]}, 32'd0);
        check("rst_fail",  {21'd0, fidx_s[0], fgot_s[0]}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Correct calculator, full sweep.
        mode = 0;
        p0 = pulses[0];
        pulse_start(0);
        check("ok_busy", {31'd0, busy_s[0]}, 32'd1);
        wait_tdone(0, "ok_tdone");
        check("ok_pulses", pulses[0] - p0, 32'd256);
        check("ok_pass",   {31'd0, pass_s[0]}, 32'd1);
        check("ok_err",    {23'd0, err_s[0]},  32'd0);
        check("ok_tmo",    {31'd0, tmo_s[0]},  32'd0);
        check("ok_last",   {24'd0, in1_s[0], in2_s[0], op_s[0]}, 32'hff);
        check("ok_idle",   {30'd0, busy_s[0], go_s[0]}, 32'd0);
        repeat (10) @(negedge clk);
        check("ok_hold",   pulses[0] - p0, 32'd256);

        // Faulty sub at 2-5, abort on first mismatch.
        mode = 1;
        pulse_start(0);
        wait_tdone(0, "stop_tdone");
        check("stop_fidx", {24'd0, fidx_s[0]}, 32'h56);
        check("stop_fgot", {29'd0, fgot_s[0]}, 32'd3);
        check("stop_err",  {23'd0, err_s[0]},  32'd1);
        check("stop_pass", {31'd0, pass_s[0]}, 32'd0);
        check("stop_vec",  {24'd0, in1_s[0], in2_s[0], op_s[0]}, 32'h56);

        // Same fault, full sweep counting errors.
        p0 = pulses[1];
        pulse_start(1);
        wait_tdone(1, "full_tdone");
        check("full_pulses", pulses[1] - p0, 32'd256);
        check("full_err",  {23'd0, err_s[1]},  32'd1);
        check("full_fidx", {24'd0, fidx_s[1]}, 32'h56);
        check("full_fgot", {29'd0, fgot_s[1]}, 32'd3);
        check("full_pass", {31'd0, pass_s[1]}, 32'd0);
        check("full_tmo",  {31'd0, tmo_s[1]},  32'd0);

        // Calculator never answers: ISSUE plus TIMEOUT wait cycles, then abort.
        mode = 2;
        h0 = hicyc[0];
        pulse_start(0);
        wait_tdone(0, "nodone_tdone");
        check("nodone_tmo",  {31'd0, tmo_s[0]},  32'd1);
        check("nodone_pass", {31'd0, pass_s[0]}, 32'd0);
        check("nodone_go",   {31'd0, go_s[0]},   32'd0);
        check("nodone_err",  {23'd0, err_s[0]},  32'd0);
        check("nodone_gocyc", hicyc[0] - h0, TIMEOUT + 1);

        // done stuck high: vector 0 completes, release times out.
        mode = 3;
        p0 = pulses[0];
        pulse_start(0);
        wait_tdone(0, "stuck_tdone");
        check("stuck_tmo",    {31'd0, tmo_s[0]},  32'd1);
        check("stuck_err",    {23'd0, err_s[0]},  32'd0);
        check("stuck_pass",   {31'd0, pass_s[0]}, 32'd0);
        check("stuck_pulses", pulses[0] - p0, 32'd1);
        check("stuck_vec",    {24'd0, in1_s[0], in2_s[0], op_s[0]}, 32'd0);

        // Reset during WAIT at vector 100, then a clean restart.
        mode = 0;
        repeat (2) @(negedge clk);
        pulse_start(0);
        n = 0;
        while (!(go_s[0] && {in1_s[0], in2_s[0], op_s[0]} == 8'd100) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", {31'd0, go_s[0]}, 32'd1);
        @(negedge clk);
        check("mid_wait_busy", {31'd0, busy_s[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_go",   {31'd0, go_s[0]},   32'd0);
        check("mid_busy", {31'd0, busy_s[0]}, 32'd0);
        check("mid_err",  {23'd0, err_s[0]},  32'd0);
        check("mid_vec",  {24'd0, in1_s[0], in2_s[0], op_s[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        p0 = pulses[0];
        pulse_start(0);
        wait_tdone(0, "re_tdone");
        check("re_pulses", pulses[0] - p0, 32'd256);
        check("re_pass",   {31'd0, pass_s[0]}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
